// File: rtl/exe_stage_mc.sv
// Multi-cycle execute stage: single-cycle ALU plus an iterative MUL/MLA unit,
// with a ready/valid upstream handshake, pipeline flush and registered results.
module exe_stage_mc #(
    parameter int DATA_W   = 32,
    parameter int MUL_STEP = 2,
    parameter int REG_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic              mul_in,
    input  logic              acc_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic              c_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val2_in,
    input  logic [DATA_W-1:0] val_rs_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [REG_W-1:0]  dest_in,
    output logic              out_valid,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              b_out,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [DATA_W-1:0] branch_address,
    output logic [REG_W-1:0]  dest_out,
    output logic [3:0]        status_out
);

    localparam int ITERS = DATA_W / MUL_STEP;
    localparam int CNT_W = $clog2(ITERS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_e;

    state_e state_q, state_d;

    logic              accept;
    logic              mul_last;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] product_q, product_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] alu_res_q;
    logic [DATA_W-1:0] val_rm_q;
    logic [DATA_W-1:0] branch_q;
    logic [REG_W-1:0]  dest_q;
    logic [3:0]        status_q;
    logic              wb_q, mem_r_q, mem_w_q, b_q, s_q;

    logic [DATA_W-1:0] alu_res_c;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;
    logic              cin, arith;
    logic              alu_n, alu_z, alu_c, alu_v;
    logic signed [25:0] br_off;

    assign accept   = in_valid && in_ready && !flush;
    assign mul_last = (state_q == ST_MUL) && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = mul_in ? ST_MUL : ST_DONE;
            ST_MUL:  if (mul_last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    // Subtractions are done as a + ~b + cin so the adder carry is the ARM no-borrow flag.
    always_comb begin
        alu_res_c = '0;
        b_eff     = val2_in;
        cin       = 1'b0;
        arith     = 1'b0;
        case (exe_cmd_in)
            4'b0001: alu_res_c = val2_in;
            4'b1001: alu_res_c = ~val2_in;
            4'b0010: arith = 1'b1;
            4'b0011: begin arith = 1'b1; cin = c_in; end
            4'b0100: begin arith = 1'b1; b_eff = ~val2_in; cin = 1'b1; end
            4'b0101: begin arith = 1'b1; b_eff = ~val2_in; cin = c_in; end
            4'b0110: alu_res_c = val_rn_in & val2_in;
            4'b0111: alu_res_c = val_rn_in | val2_in;
            4'b1000: alu_res_c = val_rn_in ^ val2_in;
            default: alu_res_c = '0;
        endcase
        sum = {1'b0, val_rn_in} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin};
        if (arith) alu_res_c = sum[DATA_W-1:0];
        alu_n = alu_res_c[DATA_W-1];
        alu_z = (alu_res_c == '0);
        alu_c = arith ? sum[DATA_W] : status_q[1];
        alu_v = arith ? ((val_rn_in[DATA_W-1] == b_eff[DATA_W-1]) &&
                         (sum[DATA_W-1] != val_rn_in[DATA_W-1])) : status_q[0];
    end

    assign product_d = product_q + mcand_q * DATA_W'(mplier_q[MUL_STEP-1:0]);
    assign mcand_d   = mcand_q << MUL_STEP;
    assign mplier_d  = mplier_q >> MUL_STEP;
    assign cnt_d     = cnt_q - CNT_W'(1);
    assign br_off    = $signed({signed_imm_24_in, 2'b00});

    // Status is written on the edge entering DONE so it is visible alongside out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            product_q <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            alu_res_q <= '0;
            val_rm_q  <= '0;
            branch_q  <= '0;
            dest_q    <= '0;
            status_q  <= '0;
            wb_q      <= 1'b0;
            mem_r_q   <= 1'b0;
            mem_w_q   <= 1'b0;
            b_q       <= 1'b0;
            s_q       <= 1'b0;
        end else begin
            if (accept) begin
                val_rm_q <= val_rm_in;
                branch_q <= pc_in + DATA_W'(br_off);
                dest_q   <= dest_in;
                wb_q     <= wb_en_in;
                mem_r_q  <= mem_r_en_in;
                mem_w_q  <= mem_w_en_in;
                b_q      <= b_in;
                s_q      <= s_in;
                if (mul_in) begin
                    product_q <= acc_in ? val_rm_in : '0;
                    mcand_q   <= val_rn_in;
                    mplier_q  <= val_rs_in;
                    cnt_q     <= CNT_W'(ITERS);
                end else begin
                    alu_res_q <= alu_res_c;
                    if (s_in) status_q <= {alu_n, alu_z, alu_c, alu_v};
                end
            end
            if (state_q == ST_MUL && !flush) begin
                product_q <= product_d;
                mcand_q   <= mcand_d;
                mplier_q  <= mplier_d;
                cnt_q     <= cnt_d;
                if (mul_last) begin
                    alu_res_q <= product_d;
                    if (s_q) status_q <= {product_d[DATA_W-1], product_d == '0, status_q[1:0]};
                end
            end
        end
    end

    assign alu_res        = alu_res_q;
    assign val_rm_out     = val_rm_q;
    assign branch_address = branch_q;
    assign dest_out       = dest_q;
    assign status_out     = status_q;
    assign wb_en_out      = wb_q & out_valid;
    assign mem_r_en_out   = mem_r_q & out_valid;
    assign mem_w_en_out   = mem_w_q & out_valid;
    assign b_out          = b_q & out_valid;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed self-checking bench for exe_stage_mc: default 32-bit instance plus a
// 16-bit, one-bit-per-cycle instance; expected results flow through scoreboard queues.
module tb_exe_stage_mc;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  nzcv;
        logic [3:0]  dest;
        logic [31:0] br;
        logic [31:0] rm;
        logic [3:0]  ctrl;
    } exp_t;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  nzcv;
    } exp16_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, flush;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, mul_in, acc_in, c_in;
    logic [3:0]  exe_cmd_in;
    logic [31:0] pc_in, val_rn_in, val2_in, val_rs_in, val_rm_in;
    logic [23:0] signed_imm_24_in;
    logic [3:0]  dest_in;
    logic        in_ready, out_valid, wb_en_out, mem_r_en_out, mem_w_en_out, b_out;
    logic [31:0] alu_res, val_rm_out, branch_address;
    logic [3:0]  dest_out, status_out;

    logic        inValid16, flush16, mul16, s16;
    logic [15:0] rn16, rs16;
    logic        inReady16, outValid16, wb16, memR16, memW16, b16;
    logic [15:0] res16, rmOut16, br16;
    logic [3:0]  dest16, status16;

    exp_t   q[$];
    exp16_t q16[$];
    int          checks = 0;
    int          failures = 0;
    int          opId = 0;
    logic [3:0]  expStatus = 4'b0000;
    logic [31:0] lastRes = 32'd0;

    exe_stage_mc u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .b_in(b_in), .s_in(s_in), .mul_in(mul_in), .acc_in(acc_in),
        .exe_cmd_in(exe_cmd_in), .c_in(c_in), .pc_in(pc_in),
        .signed_imm_24_in(signed_imm_24_in), .val_rn_in(val_rn_in), .val2_in(val2_in),
        .val_rs_in(val_rs_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
        .out_valid(out_valid), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
        .mem_w_en_out(mem_w_en_out), .b_out(b_out), .alu_res(alu_res),
        .val_rm_out(val_rm_out), .branch_address(branch_address),
        .dest_out(dest_out), .status_out(status_out)
    );

    exe_stage_mc #(.DATA_W(16), .MUL_STEP(1), .REG_W(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(inValid16), .in_ready(inReady16), .flush(flush16),
        .wb_en_in(1'b0), .mem_r_en_in(1'b0), .mem_w_en_in(1'b0),
        .b_in(1'b0), .s_in(s16), .mul_in(mul16), .acc_in(1'b0),
        .exe_cmd_in(4'd0), .c_in(1'b0), .pc_in(16'd0),
        .signed_imm_24_in(24'd0), .val_rn_in(rn16), .val2_in(16'd0),
        .val_rs_in(rs16), .val_rm_in(16'd0), .dest_in(4'd0),
        .out_valid(outValid16), .wb_en_out(wb16), .mem_r_en_out(memR16),
        .mem_w_en_out(memW16), .b_out(b16), .alu_res(res16),
        .val_rm_out(rmOut16), .branch_address(br16),
        .dest_out(dest16), .status_out(status16)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference ALU written with wide signed/unsigned arithmetic; returns {nzcv, result}.
    function automatic logic [35:0] aluModel(input logic [3:0] cmd, input logic [31:0] a,
                                             input logic [31:0] b, input logic c,
                                             input logic [3:0] st);
        logic [31:0] r;
        logic        cf, vf;
        longint      sa, sb, wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        cf = st[1];
        vf = st[0];
        wide = 0;
        case (cmd)
            4'b0001: r = b;
            4'b1001: r = ~b;
            4'b0010: begin r = a + b;      cf = ({1'b0, a} + {1'b0, b}) > 33'hFFFFFFFF;      wide = sa + sb; end
            4'b0011: begin r = a + b + {31'd0, c}; cf = ({1'b0, a} + {1'b0, b} + {32'd0, c}) > 33'hFFFFFFFF; wide = sa + sb + longint'(c); end
            4'b0100: begin r = a - b;      cf = (a >= b);                                     wide = sa - sb; end
            4'b0101: begin r = a - b - {31'd0, !c}; cf = ({1'b0, a} >= {1'b0, b} + {32'd0, !c}); wide = sa - sb - longint'(!c); end
            4'b0110: r = a & b;
            4'b0111: r = a | b;
            4'b1000: r = a ^ b;
            default: r = 32'd0;
        endcase
        if (cmd inside {4'b0010, 4'b0011, 4'b0100, 4'b0101})
            vf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
        return {r[31], r == 32'd0, cf, vf, r};
    endfunction

    task automatic setupOp();
        opId++;
        dest_in          = opId[3:0];
        pc_in            = 32'h0000_1000 + 32'(opId * 16);
        signed_imm_24_in = opId[0] ? 24'hFFFFF0 : 24'(opId);
        wb_en_in         = opId[0];
        mem_r_en_in      = opId[1];
        mem_w_en_in      = opId[2];
        b_in             = opId[3];
        val_rm_in        = 32'hA5A5_0000 ^ 32'(opId);
    endtask

    task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic s);
        setupOp();
        mul_in     = 1'b0;
        acc_in     = 1'b0;
        exe_cmd_in = cmd;
        val_rn_in  = a;
        val2_in    = b;
        val_rs_in  = 32'd0;
        c_in       = c;
        s_in       = s;
        in_valid   = 1'b1;
    endtask

    task automatic applyMul(input logic [31:0] rn, input logic [31:0] rs, input logic [31:0] rm,
                            input logic acc, input logic s);
        setupOp();
        mul_in     = 1'b1;
        acc_in     = acc;
        exe_cmd_in = 4'd0;
        val_rn_in  = rn;
        val2_in    = 32'd0;
        val_rs_in  = rs;
        val_rm_in  = rm;
        c_in       = 1'b0;
        s_in       = s;
        in_valid   = 1'b1;
    endtask

    // Called when the currently driven operation is known to be accepted on the next edge.
    task automatic pushExpected();
        exp_t            e;
        logic [35:0]     m;
        logic [31:0]     r;
        logic [3:0]      st;
        logic signed [31:0] simm;
        if (mul_in) begin
            r  = val_rn_in * val_rs_in + (acc_in ? val_rm_in : 32'd0);
            st = {r[31], r == 32'd0, expStatus[1:0]};
        end else begin
            m  = aluModel(exe_cmd_in, val_rn_in, val2_in, c_in, expStatus);
            r  = m[31:0];
            st = m[35:32];
        end
        if (s_in) expStatus = st;
        simm   = {{8{signed_imm_24_in[23]}}, signed_imm_24_in};
        e.res  = r;
        e.nzcv = expStatus;
        e.dest = dest_in;
        e.br   = pc_in + 32'(simm * 4);
        e.rm   = val_rm_in;
        e.ctrl = {wb_en_in, mem_r_en_in, mem_w_en_in, b_in};
        lastRes = r;
        q.push_back(e);
    endtask

    task automatic runAlu(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input logic c, input logic s);
        applyStimulus(cmd, a, b, c, s);
        pushExpected();
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput({tag, "_valid_T1"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_ready_T1"}, 64'(in_ready), 64'd0);
        @(negedge clk);
        checkOutput({tag, "_valid_T2"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_ready_T2"}, 64'(in_ready), 64'd1);
        checkOutput({tag, "_ctrl_gated"}, 64'({wb_en_out, mem_r_en_out, mem_w_en_out, b_out}), 64'd0);
        checkOutput({tag, "_res_hold"}, 64'(alu_res), 64'(lastRes));
    endtask

    always @(negedge clk) begin : monitorMain
        exp_t e;
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                checkOutput("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                checkOutput("sb_alu_res", 64'(alu_res), 64'(e.res));
                checkOutput("sb_status", 64'(status_out), 64'(e.nzcv));
                checkOutput("sb_dest", 64'(dest_out), 64'(e.dest));
                checkOutput("sb_branch", 64'(branch_address), 64'(e.br));
                checkOutput("sb_val_rm", 64'(val_rm_out), 64'(e.rm));
                checkOutput("sb_ctrl", 64'({wb_en_out, mem_r_en_out, mem_w_en_out, b_out}), 64'(e.ctrl));
            end
        end
    end

    always @(negedge clk) begin : monitor16
        exp16_t e;
        if (outValid16 === 1'b1) begin
            if (q16.size() == 0) begin
                checkOutput("unexpected_valid16", 64'd1, 64'd0);
            end else begin
                e = q16.pop_front();
                checkOutput("sb16_alu_res", 64'(res16), 64'(e.res));
                checkOutput("sb16_status", 64'(status16), 64'(e.nzcv));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin : stimulus
        int lat;
        int readyAt;
        logic [3:0] statusBefore;
        rst = 1'b1;
        in_valid = 1'b0; flush = 1'b0;
        wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; b_in = 1'b0;
        s_in = 1'b0; mul_in = 1'b0; acc_in = 1'b0; c_in = 1'b0;
        exe_cmd_in = 4'd0; pc_in = 32'd0; val_rn_in = 32'd0; val2_in = 32'd0;
        val_rs_in = 32'd0; val_rm_in = 32'd0; signed_imm_24_in = 24'd0; dest_in = 4'd0;
        inValid16 = 1'b0; flush16 = 1'b0; mul16 = 1'b0; s16 = 1'b0; rn16 = 16'd0; rs16 = 16'd0;

        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_status", 64'(status_out), 64'd0);
        checkOutput("rst_alu_res", 64'(alu_res), 64'd0);
        checkOutput("rst_in_ready16", 64'(inReady16), 64'd1);
        rst = 1'b0;

        runAlu("add_s",   4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        runAlu("sbc_s",   4'b0101, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1);
        runAlu("eor_nos", 4'b1000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0);
        runAlu("mvn_s",   4'b1001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        runAlu("adc_s",   4'b0011, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1);
        runAlu("sub_s",   4'b0100, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        runAlu("add_c",   4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        runAlu("undef_s", 4'b1111, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1);
        runAlu("and_s",   4'b0110, 32'h0000_FF00, 32'h0000_0F0F, 1'b0, 1'b1);

        // MLA, with the next instruction held on in_valid for the whole busy period.
        applyMul(32'h0000_FFFF, 32'h0001_0001, 32'h0000_0005, 1'b1, 1'b1);
        pushExpected();
        @(negedge clk);
        applyStimulus(4'b0111, 32'h0000_00F0, 32'h0000_0F00, 1'b0, 1'b0);
        lat = 0;
        readyAt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (out_valid === 1'b1 && lat == 0) lat = k;
            if (in_ready === 1'b1) begin
                readyAt = k;
                pushExpected();
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("mla_latency", 64'(lat), 64'd17);
        checkOutput("stall_accept_cycle", 64'(readyAt), 64'd18);
        checkOutput("stall_b_valid", 64'(out_valid), 64'd1);
        repeat (3) @(negedge clk);
        checkOutput("stall_no_double", 64'(q.size()), 64'd0);
        checkOutput("stall_ready_idle", 64'(in_ready), 64'd1);

        // flush and in_valid together in IDLE: flush wins, then the op goes through.
        applyStimulus(4'b0001, 32'h0000_0000, 32'h0000_0055, 1'b0, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flushprio_ready", 64'(in_ready), 64'd1);
        checkOutput("flushprio_valid", 64'(out_valid), 64'd0);
        flush = 1'b0;
        pushExpected();
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("flushprio_accept", 64'(out_valid), 64'd1);
        @(negedge clk);

        // flush in the fifth MUL cycle; a zero product would have set Z.
        statusBefore = expStatus;
        applyMul(32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_ready", 64'(in_ready), 64'd1);
        checkOutput("flush_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_status", 64'(status_out), 64'(statusBefore));
        applyStimulus(4'b0010, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0);
        pushExpected();
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("flush_new_op_valid", 64'(out_valid), 64'd1);
        repeat (20) @(negedge clk);
        checkOutput("flush_status_after", 64'(status_out), 64'(statusBefore));

        // Reset held two cycles in the middle of a multiply.
        applyMul(32'h0000_0011, 32'h0000_0022, 32'h0000_0000, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rstmul_valid", 64'(out_valid), 64'd0);
        checkOutput("rstmul_status", 64'(status_out), 64'd0);
        checkOutput("rstmul_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        expStatus = 4'b0000;
        repeat (25) @(negedge clk);
        checkOutput("rstmul_no_completion", 64'(q.size()), 64'd0);
        checkOutput("rstmul_status_after", 64'(status_out), 64'd0);

        // 16-bit, one bit per cycle: flush in MUL cycle 5, then the full multiply.
        mul16 = 1'b1; s16 = 1'b1; rn16 = 16'h1234; rs16 = 16'h0003; inValid16 = 1'b1;
        @(negedge clk);
        inValid16 = 1'b0;
        repeat (4) @(negedge clk);
        flush16 = 1'b1;
        @(negedge clk);
        flush16 = 1'b0;
        checkOutput("flush16_ready", 64'(inReady16), 64'd1);
        checkOutput("flush16_valid", 64'(outValid16), 64'd0);
        checkOutput("flush16_status", 64'(status16), 64'd0);
        inValid16 = 1'b1;
        q16.push_back('{res: 16'h369C, nzcv: 4'b0000});
        @(negedge clk);
        inValid16 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (outValid16 === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        checkOutput("mul16_latency", 64'(lat), 64'd17);
        repeat (3) @(negedge clk);

        checkOutput("final_queue_empty", 64'(q.size()), 64'd0);
        checkOutput("final_queue16_empty", 64'(q16.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exe_stage_mc.md
# exe_stage_mc

Parametrised multi-cycle execute stage for the ARM-subset pipeline. It supersedes the single-cycle execute stage. It adds:
- configurable datapath width;
- an iterative MUL/MLA unit with a configurable number of bits retired per cycle;
- a ready/valid upstream handshake that stalls the ID/EXE boundary while a multiply is in flight;
- a pipeline flush.

It sits between the ID/EXE register and the EXE/MEM register. All results and control are registered inside the block.

## Interface
Parameters:
- DATA_W, 32, datapath width; must be a multiple of MUL_STEP
- MUL_STEP, 2, multiplier bits consumed per cycle (1, 2 or 4)
- REG_W, 4, destination register index width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  an operation is presented
- in_ready  out  1  block can accept; high only in IDLE
- flush  in  1  kill the in-flight operation
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in  in  1 each  control bits
- mul_in, acc_in  in  1 each  multiply; accumulate (MLA)
- exe_cmd_in  in  4  ALU command
- c_in  in  1  carry from status register file
- pc_in  in  DATA_W  PC+4 of the instruction
- signed_imm_24_in  in  24  branch offset
- val_rn_in, val2_in  in  DATA_W  operand 1; shifted/immediate operand 2
- val_rs_in  in  DATA_W  multiplier operand
- val_rm_in  in  DATA_W  store data / accumulator for MLA
- dest_in  in  REG_W  destination register
- out_valid  out  1  one-cycle strobe; outputs below are valid
- wb_en_out, mem_r_en_out, mem_w_en_out, b_out  out  1 each  registered copies, gated by out_valid
- alu_res, val_rm_out, branch_address  out  DATA_W  results
- dest_out  out  REG_W  destination
- status_out  out  4  NZCV, registered

## Operation
- **exe_cmd encoding:**
  - 0001 MOV: b
  - 1001 MVN: ~b
  - 0010 ADD
  - 0011 ADC: a+b+c_in
  - 0100 SUB
  - 0101 SBC: a-b-!c_in
  - 0110 AND
  - 0111 ORR
  - 1000 EOR
  - other values: result 0, flags N/Z only
- **Flags:**
  - N = result MSB; Z = result==0.
  - C and V are produced for ADD/ADC/SUB/SBC only (ARM carry/overflow semantics, SUB carry = no-borrow); other commands leave C and V unchanged.
- **branch_address** = pc_in + sign_extend(signed_imm_24_in)<<2, truncated to DATA_W. It is captured with every accepted operation.
- **FSM states:** IDLE, MUL, DONE.
  - IDLE, accept with mul_in=0: ALU result registered; go to DONE.
  - IDLE, accept with mul_in=1:
    - load product = acc_in ? val_rm_in : 0;
    - load multiplicand = val_rn_in, multiplier = val_rs_in;
    - load iteration counter = DATA_W/MUL_STEP;
    - go to MUL.
  - MUL, each cycle:
    - product += multiplicand * multiplier[MUL_STEP-1:0];
    - multiplicand <<= MUL_STEP; multiplier >>= MUL_STEP;
    - counter--;
    - when counter reaches 1, go to DONE after that step.
    - Result is the low DATA_W bits of rn*rs (+rm).
  - DONE: out_valid=1 for exactly one cycle; go to IDLE.
- **Status update:** status_out updates in DONE only, and only if the captured s_in was 1.
  - Multiply updates N and Z; C and V are preserved.
- **flush:** forces IDLE on the next edge from any state.
  - out_valid stays 0; status is not updated.
  - flush has priority over in_valid in the same cycle; the presented operation is not accepted.
- in_valid while in_ready=0 is ignored. Upstream must hold the instruction; the hazard unit stalls on !in_ready.

## Timing
- **Reset:** all outputs 0, state IDLE, in_ready=1 on the cycle after rst is sampled high. Reset mid-multiply discards the operation.
- **ALU op:** accepted at edge T; out_valid high during cycle T+1.
  - in_ready is low during T+1, so back-to-back ALU ops issue every 2 cycles.
- **Multiply:** accepted at T; out_valid at T+DATA_W/MUL_STEP+1.
  - With defaults: 16 MUL cycles, result at T+17.
- No downstream back-pressure; the consumer must take the data in the out_valid cycle.
- Registered outputs hold their last values when out_valid=0.
  - Exception: wb_en_out, mem_r_en_out, mem_w_en_out and b_out read 0 when out_valid=0.

## Test plan
- **Reset:** rst high 2 cycles mid-MUL → next cycle out_valid=0, status_out=0000, in_ready=1; no completion ever appears.
- **ADD with S:** 0x7FFFFFFF + 0x00000001, s_in=1 → alu_res=0x80000000, status_out=1001 (N,V), out_valid exactly one cycle at T+1.
- **SBC borrow:** 0x00000000 - 0x00000001 with c_in=1 → alu_res=0xFFFFFFFF, NZCV=1000.
- **MLA, defaults:** rn=0x0000FFFF, rs=0x00010001, rm=5, acc=1 → alu_res=0xFFFFFFFF+5 truncated=0x00000004, out_valid at T+17, in_ready low T+1..T+17, N/Z updated, C/V preserved.
- **flush / MUL_STEP=1:** flush asserted at MUL cycle 5 → no out_valid, status unchanged, new op accepted next cycle. Repeat with MUL_STEP=1 and DATA_W=16: latency 17 cycles, 0x1234*0x0003=0x369C.
- **Stall:** in_valid held high while busy → exactly one acceptance per in_ready cycle; the held instruction is not double-issued after completion.
